// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int MEM_BYTES = 256;
    localparam int MAX_WORDS = MEM_BYTES / 4;
    localparam int CSUM_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input and instruction-memory write port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    // Loader side: consumes the stream, drives the memory port.
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Stream source / memory observer side.
    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader_acc.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_acc
//  Description : MSB-first word assembler with running 32-bit additive checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_acc
    import imem_loader_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              strobe,
    input  wire logic [7:0]        data,
    output logic                   word_complete,
    output logic [CSUM_W-1:0]      word,
    output logic [CSUM_W-1:0]      csum,
    output logic [1:0]             byte_idx
);

    logic [23:0]       r_word;
    logic [1:0]        r_idx;
    logic [CSUM_W-1:0] r_csum;

    // word includes the byte currently on the input, so it is complete in the
    // same cycle as the 4th strobe while csum still excludes it.
    assign word          = {r_word, data};
    assign word_complete = strobe && (r_idx == 2'd3);
    assign csum          = r_csum;
    assign byte_idx      = r_idx;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_word <= '0;
            r_idx  <= '0;
            r_csum <= '0;
        end else if (strobe) begin
            r_word <= word[23:0];
            r_idx  <= r_idx + 2'd1;
            if (word_complete) begin
                r_csum <= r_csum + word;
            end
        end
    end

endmodule : imem_loader_acc
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Streams bytes into the instruction store, verifies a trailing
//                checksum and releases the CPU only after a good load.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 7
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [CNT_W-1:0]  word_count,
    imem_loader_if.slave           bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   cpu_hold
);

    localparam int c_MAX_WORDS = MEM_BYTES / 4;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_s_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_hold;
    logic              w_s_ready_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;
    logic              w_cpu_hold_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_words_left;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_xfer;
    logic              w_start_acc;
    logic              w_count_bad;
    logic              w_last_load;
    logic              w_word_done;
    logic [CSUM_W-1:0] w_word;
    logic [CSUM_W-1:0] w_csum;
    logic [1:0]        w_byte_idx;

    assign w_xfer      = bus.s_valid && r_s_ready;
    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
    assign w_count_bad = int'(word_count) > c_MAX_WORDS;
    assign w_last_load = w_xfer && (w_byte_idx == 2'd3) && (r_words_left == CNT_W'(1));

    imem_loader_acc u_acc (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_start_acc),
        .strobe        (w_xfer),
        .data          (bus.s_data),
        .word_complete (w_word_done),
        .word          (w_word),
        .csum          (w_csum),
        .byte_idx      (w_byte_idx)
    );

    // State register; the status outputs are registered decodes of next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_s_ready  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_s_ready  <= w_s_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (w_start_acc) begin
                    if (w_count_bad)
                        w_state_nxt = ST_ERR;
                    else if (word_count == '0)
                        w_state_nxt = ST_CHECK;
                    else
                        w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last_load)
                    w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_word_done)
                    w_state_nxt = (w_word == w_csum) ? ST_DONE : ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_s_ready_nxt  = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK);
        w_busy_nxt     = w_s_ready_nxt;
        w_done_nxt     = (w_state_nxt == ST_DONE);
        w_error_nxt    = (w_state_nxt == ST_ERR);
        w_cpu_hold_nxt = (w_state_nxt != ST_DONE);
    end

    // Address counter, word countdown and registered memory write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= w_xfer && (r_state == ST_LOAD);
            if (w_start_acc) begin
                r_addr       <= base_addr;
                r_words_left <= word_count;
            end else if (w_xfer && (r_state == ST_LOAD)) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= bus.s_data;
                r_addr      <= r_addr + ADDR_W'(1);
                if (w_word_done)
                    r_words_left <= r_words_left - CNT_W'(1);
            end
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign cpu_hold      = r_cpu_hold;

endmodule : imem_loader
`default_nettype wire
